// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready immediate extender and branch-target adder
// Ports: clk/rst (sync, active-high), flush drops in-flight entries;
//   in_valid/in_ready with mode_in, imm_in, pc_in on the decode side;
//   out_valid/out_ready with ext_out, target_out, mode_out on the execute side.
module imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W = 24,
  parameter int SHIFT = 2,
  parameter int PC_OFFSET = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [DATA_W-1:0] pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_out,
  output logic [DATA_W-1:0] target_out,
  output logic [1:0]        mode_out
);
  logic              s1_valid, s2_valid, s2_adv;
  logic [DATA_W-1:0] s1_ext, s1_pc, z8, z12, br, rot, ext;
  logic [1:0]        s1_mode;
  logic [31:0]       ra;
  // rotate amount taken modulo DATA_W so narrow datapaths wrap cleanly
  always_comb begin
    s2_adv = !s2_valid || out_ready;
    in_ready = !s1_valid || s2_adv;
    z8 = DATA_W'(imm_in[7:0]);
    z12 = DATA_W'(imm_in[11:0]);
    br = {{(DATA_W-IMM_W){imm_in[IMM_W-1]}}, imm_in} << SHIFT;
    ra = {27'd0, imm_in[11:8], 1'b0} % DATA_W;
    rot = DATA_W'({z8, z8} >> ra);
    ext = mode_in == 2'd0 ? br : mode_in == 2'd1 ? rot : mode_in == 2'd2 ? z12 : -z12;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_ext <= '0;
      s1_pc <= '0;
      s1_mode <= '0;
      ext_out <= '0;
      target_out <= '0;
      mode_out <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_ready && in_valid) begin
        s1_ext <= ext;
        s1_pc <= pc_in;
        s1_mode <= mode_in;
      end
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        ext_out <= s1_ext;
        target_out <= s1_pc + DATA_W'(PC_OFFSET) + s1_ext;
        mode_out <= s1_mode;
      end
    end
  end
  assign out_valid = s2_valid;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench for imm_extend_pipe at 32-bit and 16-bit configurations
module tb_imm_extend_pipe;
  typedef struct {
    logic [63:0] ext;
    logic [63:0] tgt;
    logic [1:0]  m;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  mode_in, mode_out;
  logic [23:0] imm_in;
  logic [31:0] pc_in, ext_out, target_out;

  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_done;
  logic [1:0]  b_mode_in, b_mode_out, b_m;
  logic [11:0] b_imm_in, b_i;
  logic [15:0] b_pc_in, b_ext_out, b_target_out, b_p;

  exp_t q[$];
  exp_t q2[$];

  imm_extend_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mode_in(mode_in), .imm_in(imm_in), .pc_in(pc_in), .out_valid(out_valid),
    .out_ready(out_ready), .ext_out(ext_out), .target_out(target_out), .mode_out(mode_out)
  );

  imm_extend_pipe #(.DATA_W(16), .IMM_W(12), .SHIFT(1), .PC_OFFSET(8)) dut16 (
    .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mode_in(b_mode_in), .imm_in(b_imm_in), .pc_in(b_pc_in), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .ext_out(b_ext_out), .target_out(b_target_out), .mode_out(b_mode_out)
  );

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // reference: plain integer arithmetic on the format rules
  function automatic logic [63:0] ref_ext(input int dw, input int iw, input int sh,
                                          input logic [1:0] m, input logic [63:0] imm);
    logic [63:0] mask, v;
    longint s;
    int r;
    mask = (64'd1 << dw) - 64'd1;
    if (m == 2'd0) begin
      s = imm[iw-1] ? longint'(imm) - (longint'(1) << iw) : longint'(imm);
      return 64'(s * (longint'(1) << sh)) & mask;
    end
    if (m == 2'd1) begin
      v = imm & 64'hFF;
      r = (2 * int'((imm >> 8) & 64'hF)) % dw;
      return ((v >> r) | (v << (dw - r))) & mask;
    end
    v = imm & 64'hFFF;
    return m == 2'd2 ? v : (64'd0 - v) & mask;
  endfunction

  function automatic logic [63:0] ref_tgt(input int dw, input logic [63:0] pc, input logic [63:0] ext);
    return (pc + 64'd8 + ext) & ((64'd1 << dw) - 64'd1);
  endfunction

  task automatic send(input logic [1:0] m, input logic [23:0] i, input logic [31:0] p, input bit rnd);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1'b1; mode_in = m; imm_in = i; pc_in = p;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    else begin
      e.ext = ref_ext(32, 24, 2, m, 64'(i));
      e.tgt = ref_tgt(32, 64'(p), e.ext);
      e.m = m;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send2(input logic [1:0] m, input logic [11:0] i, input logic [15:0] p);
    int n;
    exp_t e;
    n = 0;
    b_in_valid = 1'b1; b_mode_in = m; b_imm_in = i; b_pc_in = p;
    @(negedge clk);
    while (!b_in_ready && n < 100) begin
      @(posedge clk); #1;
      b_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!b_in_ready) chk("accept16_timeout", 64'(b_in_ready), 64'd1);
    else begin
      e.ext = ref_ext(16, 12, 1, m, 64'(i));
      e.tgt = ref_tgt(16, 64'(p), e.ext);
      e.m = m;
      q2.push_back(e);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic single(input logic [1:0] m, input logic [23:0] i, input logic [31:0] p,
                        input logic [31:0] ee, input logic [31:0] et, input string nm);
    out_ready = 1'b1;
    send(m, i, p, 1'b0);
    @(negedge clk);
    chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({nm, "_lat2"}, 64'(out_valid), 64'd1);
    chk({nm, "_ext"}, 64'(ext_out), 64'(ee));
    chk({nm, "_tgt"}, 64'(target_out), 64'(et));
    @(posedge clk); #1;
  endtask

  logic        hv = 1'b0;
  logic [31:0] pe, pt;
  logic [1:0]  pm;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush) begin
      if (hv) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_ext", 64'(ext_out), 64'(pe));
        chk("hold_tgt", 64'(target_out), 64'(pt));
        chk("hold_mode", 64'(mode_out), 64'(pm));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
        else begin
          e = q.pop_front();
          chk("ext", 64'(ext_out), e.ext);
          chk("tgt", 64'(target_out), e.tgt);
          chk("mode", 64'(mode_out), 64'(e.m));
        end
      end
    end
    hv = !rst && !flush && out_valid && !out_ready;
    pe = ext_out; pt = target_out; pm = mode_out;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!b_rst && b_out_valid && b_out_ready) begin
      if (q2.size() == 0) chk("unexpected_out16", 64'(b_out_valid), 64'd0);
      else begin
        e = q2.pop_front();
        chk("ext16", 64'(b_ext_out), e.ext);
        chk("tgt16", 64'(b_target_out), e.tgt);
        chk("mode16", 64'(b_mode_out), 64'(e.m));
      end
    end
  end

  initial begin
    int n;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_done = 1'b0;
    b_mode_in = '0; b_imm_in = '0; b_pc_in = '0;
    repeat (3) @(posedge clk);
    #1 b_rst = 1'b0;
    @(negedge clk);
    chk("rst16_valid", 64'(b_out_valid), 64'd0);
    chk("rst16_ext", 64'(b_ext_out), 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 200; k++) begin
      b_m = 2'($urandom_range(0, 3)); b_i = 12'($urandom); b_p = 16'($urandom);
      if (k == 0) begin b_m = 2'd0; b_i = 12'h800; end
      if (k == 1) begin b_m = 2'd0; b_i = 12'h7FF; end
      if (k == 2) begin b_m = 2'd1; b_i = 12'hFFF; end
      if (k == 3) begin b_m = 2'd3; b_i = 12'h000; end
      send2(b_m, b_i, b_p);
    end
    b_out_ready = 1'b1;
    n = 0;
    while (q2.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q2.size() != 0) chk("drain16", 64'(q2.size()), 64'd0);
    b_done = 1'b1;
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode_in = '0; imm_in = '0; pc_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ext", 64'(ext_out), 64'd0);
    chk("rst_tgt", 64'(target_out), 64'd0);
    chk("rst_mode", 64'(mode_out), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    single(2'd0, 24'hFFFFFE, 32'h00000100, 32'hFFFFFFF8, 32'h00000100, "branch");
    single(2'd1, 24'h0004FF, 32'h0, 32'hFF000000, 32'hFF000008, "rot4ff");
    single(2'd1, 24'h0000AB, 32'h0, 32'h000000AB, 32'h000000B3, "rot0ab");
    single(2'd2, 24'h000FFF, 32'h0, 32'h00000FFF, 32'h00001007, "up");
    single(2'd3, 24'h000004, 32'h0, 32'hFFFFFFFC, 32'h00000004, "down4");
    single(2'd3, 24'h000000, 32'h0, 32'h00000000, 32'h00000008, "down0");
    single(2'd3, 24'hABC004, 32'h0, 32'hFFFFFFFC, 32'h00000004, "down_hi");
    single(2'd0, 24'h7FFFFF, 32'hFFFFFFF0, 32'h01FFFFFC, 32'h01FFFFF4, "wrap");

    out_ready = 1'b0;
    fork
      for (int k = 1; k <= 5; k++) send(2'd0, 24'(k), 32'h0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("bp_ready_drop", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_tgt_first", 64'(target_out), 64'h0C);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send(2'd1, 24'h0000AB, 32'h40, 1'b0);
    send(2'd2, 24'h000123, 32'h44, 1'b0);
    in_valid = 1'b1; mode_in = 2'd0; imm_in = 24'h000010; pc_in = 32'h0; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready_after", 64'(in_ready), 64'd1);
    repeat (4) @(negedge clk);
    chk("flush_no_ghost", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(2'd0, 24'h000100, 32'h1000, 1'b0);
    send(2'd2, 24'h000777, 32'h2000, 1'b0);
    in_valid = 1'b1; mode_in = 2'd2; imm_in = 24'h000055; rst = 1'b1;
    @(negedge clk);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ext", 64'(ext_out), 64'd0);
    chk("mrst_tgt", 64'(target_out), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("mrst_no_ghost", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      send(2'($urandom_range(0, 3)), 24'($urandom), 32'($urandom), 1'b1);
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    drain();

    n = 0;
    while (!b_done && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (!b_done) chk("dut16_timeout", 64'(b_done), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension and branch-target unit for the ARM datapath.
- Replaces the single-mode combinational branch-offset extender.
- Supports four immediate formats: branch offset, rotated data-processing immediate, and up/down load-store offsets.
- Two-stage valid/ready pipeline between decode and execute, with flush on taken branch.

Parameters:
- DATA_W, 32, datapath width; width of ext_out, target_out and pc_in.
- IMM_W, 24, width of imm_in. Must satisfy 12 <= IMM_W <= DATA_W - SHIFT.
- SHIFT, 2, left shift applied to the branch offset (word addressing).
- PC_OFFSET, 8, pipeline PC bias added when forming the target.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discards all in-flight entries.
- in_valid  input  1  imm_in, mode_in and pc_in are valid.
- in_ready  output  1  stage 1 can accept this cycle.
- mode_in  input  2  0 branch, 1 rotated imm, 2 offset up, 3 offset down.
- imm_in  input  IMM_W  raw immediate field.
- pc_in  input  DATA_W  PC of the instruction.
- out_valid  output  1  stage-2 result is valid.
- out_ready  input  1  downstream accepts the result.
- ext_out  output  DATA_W  extended immediate.
- target_out  output  DATA_W  pc + PC_OFFSET + ext (modulo 2^DATA_W).
- mode_out  output  2  mode of the entry currently at the output.

Behaviour:
- Reset (rst=1 at an edge):
  - s1_valid, s2_valid, ext_out, target_out and mode_out all clear to 0.
  - in_ready reads 1 in the first cycle after reset.
  - Reset mid-operation drops every entry; none is ever emitted.
- Handshakes:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - s2_adv = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_adv. This is combinational and has no dependence on in_valid.
  - out_valid = s2_valid. ext_out, target_out and mode_out are held stable while out_valid & !out_ready.
- Stage 1 (registered ext, pc and mode). The ext value depends on mode:
  - mode 0: sign-extend imm_in to DATA_W, then shift left by SHIFT (arithmetic, MSB replicated).
  - mode 1: zero-extend imm_in[7:0] to DATA_W, then rotate right by 2*imm_in[11:8] within DATA_W.
  - mode 2: zero-extend imm_in[11:0].
  - mode 3: two's-complement negation of zero-extended imm_in[11:0]. imm 0 gives 0.
  - Bits of imm_in above bit 11 are ignored in modes 1-3.
- Stage 2 (registered):
  - target = s1_pc + PC_OFFSET + s1_ext. Wraps modulo 2^DATA_W; no overflow flag.
  - target is computed for all modes; consumers use it only for mode 0.
  - ext and mode pass through unchanged.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid when there is no stall.
  - Throughput is 1 per cycle.
  - Full pipeline = 2 entries; it holds with no loss under any backpressure pattern.
- Simultaneous events:
  - Stage 1 loads and stage 2 moves in the same cycle when both are enabled.
  - Output transfer and a new stage-2 load may occur in the same cycle.
- Flush:
  - Clears s1_valid and s2_valid at the edge.
  - An input presented in the same cycle as flush is dropped, even if in_ready=1.
  - Flush takes priority over any output transfer that cycle; the downstream must treat an output coinciding with flush as void.
  - Data registers need not clear on flush.
- Priority: rst > flush > normal operation.

Test Plan:
- Branch, mode 0: imm 0xFFFFFE, pc 0x00000100. Required: ext 0xFFFFFFF8, target 0x00000100, out_valid exactly 2 cycles after input transfer.
- Formats:
  - mode 1, imm 0x4FF: ext 0xFF000000.
  - mode 1, imm 0x0AB: ext 0x000000AB.
  - mode 2, imm 0xFFF: ext 0x00000FFF.
  - mode 3, imm 0x004: ext 0xFFFFFFFC.
  - mode 3, imm 0x000: ext 0x00000000.
- Backpressure: stream 5 branch entries with imm 1..5, pc 0, holding out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepted entries.
  - Outputs stay stable while stalled.
  - After release, outputs appear in order with targets 0x0C, 0x10, 0x14, 0x18, 0x1C and no loss or duplication.
- Flush: with 2 entries in flight, assert flush together with in_valid=1. Next cycle out_valid=0 and in_ready=1; the flushed input never appears.
- Reset mid-stream: assert rst with the pipeline full and out_ready=0. Next cycle out_valid=0 and ext_out = target_out = 0, and no pre-reset entry emerges afterwards.
- Wrap and parameters:
  - mode 0, imm 0x7FFFFF, pc 0xFFFFFFF0: target 0x01FFFFFC + 0xFFFFFFF8 = 0x01FFFFF4.
  - Rerun with DATA_W=16, IMM_W=12, SHIFT=1, and check sign extension and target against a reference model.
